i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- HOLD_CYC, 256: clk_50 cycles m_request is held high.
- GUARD_CYC, 1024: idle cycles after completion, for the stop condition.
- TIMEOUT_CYC, 1048576: maximum clk_50 cycles between byte completions.
REQ-002 Ports (name, direction, width, meaning):
- clk_50 in 1: system clock.
- reset_n in 1: asynchronous, active-low reset.
- cN_req in 1 (N=0,1): client transaction request, level.
- cN_wr in 1: 1 = write, 0 = read.
- cN_len in 8: byte count.
- cN_addr in 7: slave address.
- cN_subaddr in 8: register address.
- cN_txdata in 8: current write byte.
- cN_gnt out 1: client owns the master.
- cN_tx_next out 1: one-cycle pulse; the client presents the next txdata within 32 cycles.
- cN_rx_valid out 1: one-cycle pulse; cN_rxdata is valid.
- cN_rxdata out 8: captured read byte.
- cN_done out 1: one-cycle pulse at end of transaction.
- cN_err out 1: valid with done; NACK, timeout or length 0.
- m_request out 1, m_wr out 1, m_length out 8, m_address out 7, m_sub_address out 8, m_txreg out 8: drive the I2C master.
- m_rxreg in 8, m_de in 1, m_error in 1: returned from the I2C master; m_de and m_error are SCL-domain signals.

Function
REQ-003 States SHALL be IDLE, ARB, LAUNCH, RUN, GUARD; every other encoding SHALL go to IDLE.
REQ-004 IDLE -> ARB when any cN_req=1.
REQ-005 ARB, single requester: grant it.
REQ-006 ARB, both requesting: grant the client not granted last; last_gnt resets to 1, so client 0 wins first.
REQ-007 ARB -> LAUNCH on the next cycle; cN_gnt=1 from that cycle until GUARD exits.
REQ-008 m_wr, m_length, m_address, m_sub_address and m_txreg SHALL be registered copies of the granted client's fields, latched in ARB.
REQ-009 m_txreg SHALL re-latch cN_txdata 32 cycles after each cN_tx_next.
REQ-010 cN_len=0 in ARB: skip LAUNCH/RUN, go to GUARD, pulse done with err=1, and never assert m_request.
REQ-011 LAUNCH: m_request=1 for exactly HOLD_CYC cycles, then 0, then -> RUN.
REQ-012 m_de and m_error SHALL each pass through a 2-flop synchronizer; rising edges SHALL be detected on the synchronized signals.
REQ-013 RUN: each m_de rising edge increments the 8-bit byte_cnt, cleared in ARB, and reloads the timeout counter.
REQ-014 RUN, read: on each de edge, rxdata <= m_rxreg and rx_valid pulses the following cycle.
REQ-015 RUN, write: on each de edge, tx_next pulses the following cycle, except when byte_cnt reaches len.
REQ-016 A m_error rising edge during LAUNCH or RUN SHALL set err_flag; the transaction still runs to completion.
REQ-017 RUN -> GUARD when byte_cnt == len; done pulses on GUARD entry, and err = err_flag.
REQ-018 RUN -> GUARD with err=1 when the timeout counter reaches TIMEOUT_CYC without a de edge.
REQ-019 GUARD SHALL wait GUARD_CYC cycles, then drop gnt and go to IDLE; requests during GUARD are not arbitrated until IDLE.
REQ-020 Deasserting cN_req after grant SHALL be ignored.
REQ-021 A de edge outside RUN SHALL be discarded.
REQ-022 All counters SHALL saturate, not wrap.

Reset
REQ-023 reset_n=0 SHALL asynchronously force:
- state=IDLE, last_gnt=1;
- all counters, err_flag and synchronizers = 0;
- all outputs = 0, including m_request=0 and m_txreg=0.
REQ-024 Reset mid-RUN SHALL produce no done pulse; a full master cycle SHALL be required before the next grant.

Structure
REQ-025 State encodings and parameter defaults SHALL live in the shared package i2c_pkg.
REQ-026 The synchronizer plus rising-edge detector SHALL be the sub-module sync_edge, instantiated twice.

Verification
REQ-027 c0 write, len=3, addr=0x1A, sub=0x04, data 0x11/0x22/0x33, master model ACKs all:
- m_request high for 256 cycles;
- two tx_next pulses;
- m_txreg carries 0x11, 0x22, 0x33 in order;
- done with err=0; gnt drops 1024 cycles later.
REQ-028 c1 read, len=2, model returns 0xA5 then 0x3C: two rx_valid pulses with rxdata 0xA5 then 0x3C; done with err=0.
REQ-029 c0 and c1 request on the same cycle after reset:
- c0 is granted first, then c1;
- next simultaneous pair: c0 granted first again (c1 was last served).
REQ-030 Master asserts m_error during address phase, write len=1: transaction completes and done arrives with err=1.
REQ-031 Boundary cases:
- len=0: done with err=1, m_request never asserted;
- no de for TIMEOUT_CYC cycles: done with err=1;
- reset_n pulsed mid-RUN: all outputs 0 immediately and no done.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared state encodings and parameter defaults for the two-client I2C master arbiter.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_GUARD  = 3'd4
  } state_t;

  localparam int HOLD_CYC_DEF    = 256;
  localparam int GUARD_CYC_DEF   = 1024;
  localparam int TIMEOUT_CYC_DEF = 1048576;

  // Cycles between a tx_next pulse and re-latching the client's write byte.
  localparam int TXD_DLY = 32;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an SCL-domain level, followed by a rising-edge detector.
module sync_edge (
  input  logic clk_50,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/i2c_arbiter.sv
// Arbitrates two clients onto one I2C master: round-robin grant, request launch,
// per-byte handshakes, timeout and a guard interval for the stop condition.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int HOLD_CYC    = HOLD_CYC_DEF,
  parameter int GUARD_CYC   = GUARD_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       c0_req,
  input  logic       c0_wr,
  input  logic [7:0] c0_len,
  input  logic [6:0] c0_addr,
  input  logic [7:0] c0_subaddr,
  input  logic [7:0] c0_txdata,
  output logic       c0_gnt,
  output logic       c0_tx_next,
  output logic       c0_rx_valid,
  output logic [7:0] c0_rxdata,
  output logic       c0_done,
  output logic       c0_err,
  input  logic       c1_req,
  input  logic       c1_wr,
  input  logic [7:0] c1_len,
  input  logic [6:0] c1_addr,
  input  logic [7:0] c1_subaddr,
  input  logic [7:0] c1_txdata,
  output logic       c1_gnt,
  output logic       c1_tx_next,
  output logic       c1_rx_valid,
  output logic [7:0] c1_rxdata,
  output logic       c1_done,
  output logic       c1_err,
  output logic       m_request,
  output logic       m_wr,
  output logic [7:0] m_length,
  output logic [6:0] m_address,
  output logic [7:0] m_sub_address,
  output logic [7:0] m_txreg,
  input  logic [7:0] m_rxreg,
  input  logic       m_de,
  input  logic       m_error,
  output logic [2:0] dbg_state
);

  localparam int TMAX = max3(HOLD_CYC, GUARD_CYC, TIMEOUT_CYC);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HOLD_END    = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] GUARD_END   = TW'(GUARD_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT_CYC - 1);

  state_t        state;
  logic          owner;
  logic          last_gnt;
  logic          pick;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_nxt;
  logic [7:0]    byte_cnt;
  logic [7:0]    byte_cnt_nxt;
  logic          err_flag;
  logic [5:0]    txd_cnt;
  logic          txd_pend;
  logic [1:0]    gnt, tx_next, rx_valid, done, err;
  logic [7:0]    rxdata0, rxdata1;
  logic          de_rise, error_rise;

  sync_edge u_de_sync (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .din     (m_de),
    .rise    (de_rise)
  );

  sync_edge u_err_sync (
    .clk_50  (clk_50),
    .reset_n (reset_n),
    .din     (m_error),
    .rise    (error_rise)
  );

  // With both clients requesting, serve the one not granted last.
  always_comb begin
    pick = c1_req & ~c0_req;
    if (c0_req && c1_req) pick = ~last_gnt;
  end

  assign timer_nxt    = (timer == '1) ? timer : timer + 1'b1;
  assign byte_cnt_nxt = (byte_cnt == 8'hFF) ? byte_cnt : byte_cnt + 8'd1;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      owner         <= 1'b0;
      last_gnt      <= 1'b1;
      timer         <= '0;
      byte_cnt      <= '0;
      err_flag      <= 1'b0;
      txd_cnt       <= '0;
      txd_pend      <= 1'b0;
      gnt           <= '0;
      tx_next       <= '0;
      rx_valid      <= '0;
      done          <= '0;
      err           <= '0;
      rxdata0       <= '0;
      rxdata1       <= '0;
      m_request     <= 1'b0;
      m_wr          <= 1'b0;
      m_length      <= '0;
      m_address     <= '0;
      m_sub_address <= '0;
      m_txreg       <= '0;
    end else begin
      tx_next  <= '0;
      rx_valid <= '0;
      done     <= '0;
      err      <= '0;

      if (txd_pend) begin
        if (txd_cnt == 6'(TXD_DLY - 1)) begin
          txd_pend <= 1'b0;
          m_txreg  <= owner ? c1_txdata : c0_txdata;
        end else begin
          txd_cnt <= txd_cnt + 6'd1;
        end
      end

      if (error_rise && (state == ST_LAUNCH || state == ST_RUN)) err_flag <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (c0_req || c1_req) state <= ST_ARB;
        end

        ST_ARB: begin
          if (!(c0_req || c1_req)) begin
            state <= ST_IDLE;
          end else begin
            owner         <= pick;
            last_gnt      <= pick;
            gnt           <= pick ? 2'b10 : 2'b01;
            m_wr          <= pick ? c1_wr : c0_wr;
            m_length      <= pick ? c1_len : c0_len;
            m_address     <= pick ? c1_addr : c0_addr;
            m_sub_address <= pick ? c1_subaddr : c0_subaddr;
            m_txreg       <= pick ? c1_txdata : c0_txdata;
            txd_pend      <= 1'b0;
            byte_cnt      <= '0;
            err_flag      <= 1'b0;
            timer         <= '0;
            if ((pick ? c1_len : c0_len) == 8'd0) begin
              state      <= ST_GUARD;
              done[pick] <= 1'b1;
              err[pick]  <= 1'b1;
            end else begin
              state     <= ST_LAUNCH;
              m_request <= 1'b1;
            end
          end
        end

        ST_LAUNCH: begin
          if (timer == HOLD_END) begin
            m_request <= 1'b0;
            timer     <= '0;
            state     <= ST_RUN;
          end else begin
            timer <= timer_nxt;
          end
        end

        ST_RUN: begin
          if (byte_cnt == m_length) begin
            state       <= ST_GUARD;
            timer       <= '0;
            done[owner] <= 1'b1;
            err[owner]  <= err_flag;
          end else if (timer == TIMEOUT_END) begin
            state       <= ST_GUARD;
            timer       <= '0;
            done[owner] <= 1'b1;
            err[owner]  <= 1'b1;
          end else if (de_rise) begin
            byte_cnt <= byte_cnt_nxt;
            timer    <= '0;
            if (m_wr) begin
              // The final byte needs no follow-up data from the client.
              if (byte_cnt_nxt != m_length) begin
                tx_next[owner] <= 1'b1;
                txd_pend       <= 1'b1;
                txd_cnt        <= '0;
              end
            end else begin
              rx_valid[owner] <= 1'b1;
              if (owner) rxdata1 <= m_rxreg;
              else       rxdata0 <= m_rxreg;
            end
          end else begin
            timer <= timer_nxt;
          end
        end

        ST_GUARD: begin
          if (timer == GUARD_END) begin
            state <= ST_IDLE;
            gnt   <= '0;
          end else begin
            timer <= timer_nxt;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign c0_gnt      = gnt[0];
  assign c1_gnt      = gnt[1];
  assign c0_tx_next  = tx_next[0];
  assign c1_tx_next  = tx_next[1];
  assign c0_rx_valid = rx_valid[0];
  assign c1_rx_valid = rx_valid[1];
  assign c0_done     = done[0];
  assign c1_done     = done[1];
  assign c0_err      = err[0];
  assign c1_err      = err[1];
  assign c0_rxdata   = rxdata0;
  assign c1_rxdata   = rxdata1;
  assign dbg_state   = state;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: directed client transactions against a simple I2C master
// model; a monitor compares every observed DUT event against an expected queue.
module tb_i2c_arbiter;
  import i2c_pkg::*;

  localparam int HOLD  = 256;
  localparam int GUARD = 1024;
  localparam int TMO   = 3000;
  localparam int W     = 24;

  localparam int T_GNT = 1, T_REQ = 2, T_TXN = 3, T_TX = 4, T_RX = 5, T_DONE = 6, T_GLEN = 7;

  logic       clk_50 = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] req, wr, gnt, tx_next, rx_valid, done, err;
  logic [7:0] len [2];
  logic [6:0] addr [2];
  logic [7:0] sub [2];
  logic [7:0] txdata [2];
  logic [7:0] rxdata [2];
  logic       m_request, m_wr, m_de, m_error;
  logic [7:0] m_length, m_sub_address, m_txreg, m_rxreg;
  logic [6:0] m_address;
  logic [2:0] dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  bit         mdl_err = 0;
  bit         mdl_silent = 0;
  logic [7:0] mdl_rx [4];

  always #10 clk_50 = ~clk_50;

  i2c_arbiter #(.HOLD_CYC(HOLD), .GUARD_CYC(GUARD), .TIMEOUT_CYC(TMO)) dut (
    .clk_50(clk_50), .reset_n(reset_n),
    .c0_req(req[0]), .c0_wr(wr[0]), .c0_len(len[0]), .c0_addr(addr[0]),
    .c0_subaddr(sub[0]), .c0_txdata(txdata[0]), .c0_gnt(gnt[0]), .c0_tx_next(tx_next[0]),
    .c0_rx_valid(rx_valid[0]), .c0_rxdata(rxdata[0]), .c0_done(done[0]), .c0_err(err[0]),
    .c1_req(req[1]), .c1_wr(wr[1]), .c1_len(len[1]), .c1_addr(addr[1]),
    .c1_subaddr(sub[1]), .c1_txdata(txdata[1]), .c1_gnt(gnt[1]), .c1_tx_next(tx_next[1]),
    .c1_rx_valid(rx_valid[1]), .c1_rxdata(rxdata[1]), .c1_done(done[1]), .c1_err(err[1]),
    .m_request(m_request), .m_wr(m_wr), .m_length(m_length), .m_address(m_address),
    .m_sub_address(m_sub_address), .m_txreg(m_txreg), .m_rxreg(m_rxreg), .m_de(m_de),
    .m_error(m_error), .dbg_state(dbg_state)
  );

  function automatic logic [W-1:0] mk(input int tag, input int c, input int d);
    return {7'(tag), 1'(c), 16'(d)};
  endfunction

  function automatic string ev_str(input logic [W-1:0] e);
    string n;
    case (int'(e[23:17]))
      T_GNT:   n = "gnt";
      T_REQ:   n = "req_cycles";
      T_TXN:   n = "tx_next";
      T_TX:    n = "m_txreg";
      T_RX:    n = "rxdata";
      T_DONE:  n = "done_err";
      T_GLEN:  n = "gnt_hold";
      default: n = "unknown";
    endcase
    return $sformatf("%s[c%0d]=0x%0h", n, e[16], e[15:0]);
  endfunction

  task automatic push(input int tag, input int c, input int d);
    exp_q.push_back(mk(tag, c, d));
  endtask

  task automatic check_ev(input logic [W-1:0] act);
    logic [W-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event got=%s required=none", ev_str(act));
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        failures++;
        $display("FAIL event got=%s required=%s", ev_str(act), ev_str(e));
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    failures++;
    $display("FAIL %s wait budget expired got=timeout required=event", name);
  endtask

  // One client transaction: request, drop request on grant, feed write bytes, wait done and release.
  task automatic client_txn(input int c, input logic w, input logic [7:0] n, input logic [6:0] a,
                            input logic [7:0] s, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2);
    logic [7:0] d [3];
    int idx;
    int budget;
    d[0] = d0; d[1] = d1; d[2] = d2;
    @(negedge clk_50);
    wr[c] = w; len[c] = n; addr[c] = a; sub[c] = s; txdata[c] = d0; req[c] = 1'b1;
    budget = 0;
    while (!gnt[c] && budget < 20000) begin @(negedge clk_50); budget++; end
    req[c] = 1'b0;
    if (!gnt[c]) begin expire($sformatf("gnt_c%0d", c)); return; end
    check($sformatf("m_address_c%0d", c), 32'(m_address), 32'(a));
    check($sformatf("m_sub_address_c%0d", c), 32'(m_sub_address), 32'(s));
    check($sformatf("m_length_c%0d", c), 32'(m_length), 32'(n));
    check($sformatf("m_wr_c%0d", c), 32'(m_wr), 32'(w));
    idx = 0;
    budget = 0;
    while (!done[c] && budget < 20000) begin
      if (tx_next[c] && idx < 2) begin idx++; txdata[c] = d[idx]; end
      @(negedge clk_50);
      budget++;
    end
    if (!done[c]) begin expire($sformatf("done_c%0d", c)); return; end
    budget = 0;
    while (gnt[c] && budget < 5000) begin @(negedge clk_50); budget++; end
    if (gnt[c]) expire($sformatf("gnt_release_c%0d", c));
  endtask

  // I2C master model: optional error during the address phase, then one de pulse per byte.
  initial begin
    m_de = 1'b0; m_error = 1'b0; m_rxreg = '0;
    forever begin
      @(posedge m_request);
      if (mdl_err) begin
        repeat (50) @(negedge clk_50);
        m_error = 1'b1;
        repeat (4) @(negedge clk_50);
        m_error = 1'b0;
      end
      @(negedge m_request);
      if (!mdl_silent) begin
        for (int k = 0; k < int'(m_length) && k < 4; k++) begin
          repeat (60) @(negedge clk_50);
          m_rxreg = mdl_rx[k];
          repeat (20) @(negedge clk_50);
          m_de = 1'b1;
          repeat (4) @(negedge clk_50);
          m_de = 1'b0;
        end
      end
    end
  end

  // Monitor: turns DUT output activity into events and compares them in order.
  initial begin
    logic [1:0] prev_gnt;
    logic prev_req, prev_de;
    int req_cnt, glen_cnt;
    bit glen_on;
    prev_gnt = '0; prev_req = 1'b0; prev_de = 1'b0;
    req_cnt = 0; glen_cnt = 0; glen_on = 0;
    forever begin
      @(posedge clk_50); #1;
      if (!reset_n) begin
        prev_gnt = '0; prev_req = 1'b0; prev_de = 1'b0;
        req_cnt = 0; glen_on = 0;
      end else begin
        for (int c = 0; c < 2; c++) if (gnt[c] && !prev_gnt[c]) check_ev(mk(T_GNT, c, 0));
        if (m_request) req_cnt++;
        if (prev_req && !m_request) begin check_ev(mk(T_REQ, 0, req_cnt)); req_cnt = 0; end
        for (int c = 0; c < 2; c++) if (tx_next[c]) check_ev(mk(T_TXN, c, 0));
        if (m_de && !prev_de && m_wr) check_ev(mk(T_TX, 0, int'(m_txreg)));
        for (int c = 0; c < 2; c++) if (rx_valid[c]) check_ev(mk(T_RX, c, int'(rxdata[c])));
        if (glen_on) begin
          glen_cnt++;
          if (gnt == 2'b00) begin check_ev(mk(T_GLEN, 0, glen_cnt)); glen_on = 0; end
        end
        for (int c = 0; c < 2; c++)
          if (done[c]) begin check_ev(mk(T_DONE, c, int'(err[c]))); glen_on = 1; glen_cnt = 0; end
        prev_gnt = gnt; prev_req = m_request; prev_de = m_de;
      end
    end
  end

  initial begin
    int budget;
    req = '0; wr = '0;
    for (int c = 0; c < 2; c++) begin len[c] = '0; addr[c] = '0; sub[c] = '0; txdata[c] = '0; end
    for (int k = 0; k < 4; k++) mdl_rx[k] = '0;
    reset_n = 1'b0;
    repeat (5) @(negedge clk_50);
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_m_request", 32'(m_request), 32'h0);
    check("reset_m_txreg", 32'(m_txreg), 32'h0);
    check("reset_pulses", 32'({done, err, tx_next, rx_valid}), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    repeat (3) @(negedge clk_50);

    // c0 write of three bytes
    push(T_GNT, 0, 0); push(T_REQ, 0, HOLD);
    push(T_TX, 0, 'h11); push(T_TXN, 0, 0);
    push(T_TX, 0, 'h22); push(T_TXN, 0, 0);
    push(T_TX, 0, 'h33);
    push(T_DONE, 0, 0); push(T_GLEN, 0, GUARD);
    client_txn(0, 1'b1, 8'd3, 7'h1A, 8'h04, 8'h11, 8'h22, 8'h33);

    // c1 read of two bytes
    mdl_rx[0] = 8'hA5; mdl_rx[1] = 8'h3C;
    push(T_GNT, 1, 0); push(T_REQ, 0, HOLD);
    push(T_RX, 1, 'hA5); push(T_RX, 1, 'h3C);
    push(T_DONE, 1, 0); push(T_GLEN, 0, GUARD);
    client_txn(1, 1'b0, 8'd2, 7'h50, 8'h10, 8'h00, 8'h00, 8'h00);

    // simultaneous requests right after reset, twice
    @(negedge clk_50); reset_n = 1'b0;
    repeat (3) @(negedge clk_50); reset_n = 1'b1;
    for (int p = 0; p < 2; p++) begin
      push(T_GNT, 0, 0); push(T_REQ, 0, HOLD); push(T_TX, 0, 'hC0 + p);
      push(T_DONE, 0, 0); push(T_GLEN, 0, GUARD);
      push(T_GNT, 1, 0); push(T_REQ, 0, HOLD); push(T_TX, 0, 'hD0 + p);
      push(T_DONE, 1, 0); push(T_GLEN, 0, GUARD);
      fork
        client_txn(0, 1'b1, 8'd1, 7'h21, 8'h01, 8'(8'hC0 + p), 8'h00, 8'h00);
        client_txn(1, 1'b1, 8'd1, 7'h22, 8'h02, 8'(8'hD0 + p), 8'h00, 8'h00);
      join
    end

    // master error during the address phase
    mdl_err = 1;
    push(T_GNT, 0, 0); push(T_REQ, 0, HOLD); push(T_TX, 0, 'h5A);
    push(T_DONE, 0, 1); push(T_GLEN, 0, GUARD);
    client_txn(0, 1'b1, 8'd1, 7'h30, 8'h07, 8'h5A, 8'h00, 8'h00);
    mdl_err = 0;

    // zero length: no m_request at all
    push(T_GNT, 1, 0); push(T_DONE, 1, 1); push(T_GLEN, 0, GUARD);
    client_txn(1, 1'b1, 8'd0, 7'h31, 8'h08, 8'h00, 8'h00, 8'h00);

    // master never delivers a byte
    mdl_silent = 1;
    push(T_GNT, 0, 0); push(T_REQ, 0, HOLD); push(T_DONE, 0, 1); push(T_GLEN, 0, GUARD);
    client_txn(0, 1'b0, 8'd2, 7'h32, 8'h09, 8'h00, 8'h00, 8'h00);

    // reset while in RUN: outputs clear at once and no done follows
    push(T_GNT, 0, 0); push(T_REQ, 0, HOLD);
    @(negedge clk_50);
    wr[0] = 1'b1; len[0] = 8'd1; addr[0] = 7'h33; sub[0] = 8'h0A; txdata[0] = 8'h99; req[0] = 1'b1;
    budget = 0;
    while (!gnt[0] && budget < 1000) begin @(negedge clk_50); budget++; end
    req[0] = 1'b0;
    if (!gnt[0]) expire("gnt_c0_reset_case");
    repeat (HOLD + 100) @(negedge clk_50);
    check("pre_reset_state", 32'(dbg_state), 32'(ST_RUN));
    reset_n = 1'b0;
    #1;
    check("midrun_gnt", 32'(gnt), 32'h0);
    check("midrun_m_txreg", 32'(m_txreg), 32'h0);
    check("midrun_m_fields", 32'({m_wr, m_length, m_address, m_sub_address}), 32'h0);
    check("midrun_pulses", 32'({done, err, tx_next, rx_valid}), 32'h0);
    check("midrun_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) @(negedge clk_50);
    reset_n = 1'b1;
    repeat (200) @(negedge clk_50);
    check("post_reset_done", 32'(done), 32'h0);
    mdl_silent = 0;

    // recovery transaction after the reset
    mdl_rx[0] = 8'h77;
    push(T_GNT, 1, 0); push(T_REQ, 0, HOLD); push(T_RX, 1, 'h77);
    push(T_DONE, 1, 0); push(T_GLEN, 0, GUARD);
    client_txn(1, 1'b0, 8'd1, 7'h40, 8'h0B, 8'h00, 8'h00, 8'h00);

    repeat (10) @(negedge clk_50);
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
